// File: rtl/axil_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) with master and slave views.
interface axil_reg_slave_if
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);

    logic                  AW_valid;
    logic                  AW_ready;
    logic [ADDR_W-1:0]     AW_address;
    logic                  W_valid;
    logic                  W_ready;
    logic [31:0]           W_data;
    logic [NUM_LANES-1:0]  W_strb;
    logic                  B_valid;
    logic                  B_ready;
    logic [1:0]            B_response;
    logic                  AR_valid;
    logic                  AR_ready;
    logic [ADDR_W-1:0]     AR_address;
    logic                  R_valid;
    logic                  R_ready;
    logic [31:0]           R_data;
    logic [1:0]            R_response;

    modport master (
        output AW_valid, AW_address, W_valid, W_data, W_strb, B_ready,
               AR_valid, AR_address, R_ready,
        input  AW_ready, W_ready, B_valid, B_response,
               AR_ready, R_valid, R_data, R_response
    );

    modport slave (
        input  AW_valid, AW_address, W_valid, W_data, W_strb, B_ready,
               AR_valid, AR_address, R_ready,
        output AW_ready, W_ready, B_valid, B_response,
               AR_ready, R_valid, R_data, R_response
    );

endinterface

// File: rtl/axil_wstrb_merge.sv
// Combinational byte-lane merge: strobed lanes take the new data, others keep the old word.
module axil_wstrb_merge
    import axil_pkg::*;
(
    input  logic [31:0]          i_old,
    input  logic [31:0]          i_new,
    input  logic [NUM_LANES-1:0] i_strb,
    output logic [31:0]          o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int unsigned b = 0; b < NUM_LANES; b++) begin
            if (i_strb[b]) begin
                o_merged[8*b +: 8] = i_new[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file slave with independent write and read FSMs and flat register export.
// Optional `AXIL_CYCLE_COUNTER_EN: top register becomes a read-only free-running cycle counter.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    axil_reg_slave_if.slave            bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_q
);

    localparam int unsigned IDX_W = ADDR_W - 2;
`ifdef AXIL_CYCLE_COUNTER_EN
    localparam int unsigned WR_LIMIT = NUM_REGS - 1;
`else
    localparam int unsigned WR_LIMIT = NUM_REGS;
`endif

    wr_state_t             r_wr_state;
    rd_state_t             r_rd_state;
    logic [DATA_W-1:0]     r_regs [NUM_REGS];
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_W-1:0]     r_w_data;
    logic [NUM_LANES-1:0]  r_w_strb;
    logic                  r_aw_ready, r_w_ready, r_b_valid, r_ar_ready, r_r_valid;
    logic [1:0]            r_b_resp, r_r_resp;
    logic [DATA_W-1:0]     r_r_data;

    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic [DATA_W-1:0]     w_wr_data, w_wr_old, w_wr_new, w_rd_word;
    logic [NUM_LANES-1:0]  w_wr_strb;
    logic                  w_wr_ok, w_rd_ok;
    logic                  w_unused_addr_lsbs;

    assign w_aw_hs = bus.AW_valid & r_aw_ready;
    assign w_w_hs  = bus.W_valid  & r_w_ready;
    assign w_b_hs  = r_b_valid    & bus.B_ready;
    assign w_ar_hs = bus.AR_valid & r_ar_ready;
    assign w_r_hs  = r_r_valid    & bus.R_ready;
    assign w_unused_addr_lsbs = ^{bus.AW_address[1:0], bus.AR_address[1:0]};

    // Commit uses whichever half was latched earlier and the live value for the other half.
    always_comb begin
        w_wr_idx  = (r_wr_state == WR_HAVE_AW) ? r_aw_idx : bus.AW_address[ADDR_W-1:2];
        w_wr_data = (r_wr_state == WR_HAVE_W)  ? r_w_data : bus.W_data;
        w_wr_strb = (r_wr_state == WR_HAVE_W)  ? r_w_strb : bus.W_strb;
        w_commit  = ((r_wr_state == WR_IDLE)    && w_aw_hs && w_w_hs) ||
                    ((r_wr_state == WR_HAVE_AW) && w_w_hs) ||
                    ((r_wr_state == WR_HAVE_W)  && w_aw_hs);
        w_wr_ok   = 32'(w_wr_idx) < WR_LIMIT;
        w_rd_idx  = bus.AR_address[ADDR_W-1:2];
        w_rd_ok   = 32'(w_rd_idx) < NUM_REGS;
        w_wr_old  = '0;
        w_rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(w_wr_idx) == k) w_wr_old  = r_regs[k];
            if (32'(w_rd_idx) == k) w_rd_word = r_regs[k];
        end
    end

    axil_wstrb_merge u_merge (
        .i_old    (w_wr_old),
        .i_new    (w_wr_data),
        .i_strb   (w_wr_strb),
        .o_merged (w_wr_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
`ifdef AXIL_CYCLE_COUNTER_EN
            r_regs[NUM_REGS-1] <= r_regs[NUM_REGS-1] + DATA_W'(1);
`endif
            if (w_commit && w_wr_ok) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (32'(w_wr_idx) == k) r_regs[k] <= w_wr_new;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_aw_idx   <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
        end else if (w_commit) begin
            r_wr_state <= WR_RESP;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b1;
            r_b_resp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    r_aw_ready <= 1'b1;
                    r_w_ready  <= 1'b1;
                    if (w_aw_hs) begin
                        r_wr_state <= WR_HAVE_AW;
                        r_aw_idx   <= bus.AW_address[ADDR_W-1:2];
                        r_aw_ready <= 1'b0;
                    end else if (w_w_hs) begin
                        r_wr_state <= WR_HAVE_W;
                        r_w_data   <= bus.W_data;
                        r_w_strb   <= bus.W_strb;
                        r_w_ready  <= 1'b0;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_wr_state <= WR_IDLE;
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is sampled before any same-edge commit lands, so collisions return the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_ar_ready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rd_state <= RD_RESP;
                        r_ar_ready <= 1'b0;
                        r_r_valid  <= 1'b1;
                        r_r_data   <= w_rd_word;
                        r_r_resp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                RD_RESP: begin
                    if (w_r_hs) begin
                        r_rd_state <= RD_IDLE;
                        r_r_valid  <= 1'b0;
                        r_ar_ready <= 1'b1;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign bus.AW_ready   = r_aw_ready;
    assign bus.W_ready    = r_w_ready;
    assign bus.B_valid    = r_b_valid;
    assign bus.B_response = r_b_resp;
    assign bus.AR_ready   = r_ar_ready;
    assign bus.R_valid    = r_r_valid;
    assign bus.R_data     = r_r_data;
    assign bus.R_response = r_r_resp;

    always_comb begin
        regs_q = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_q[DATA_W*k +: DATA_W] = r_regs[k];
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized bench for axil_reg_slave against a transaction-level register-file model.
module tb_axil_reg_slave;
    localparam int NR = 8;
`ifdef AXIL_CYCLE_COUNTER_EN
    localparam int LIM = NR - 1;
`else
    localparam int LIM = NR;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NR*32-1:0] regs_q;

    axil_reg_slave_if #(.ADDR_W(8)) bus ();

    axil_reg_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(NR)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .regs_q (regs_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: register array plus queues of accepted-but-unpaired halves and pending responses
    logic [31:0] m_regs [NR];
    logic [7:0]  q_aw [$];
    logic [35:0] q_w  [$];
    logic [1:0]  q_b  [$];
    logic [33:0] q_r  [$];
    bit m_up = 0, m_live = 0;
    int b_cnt = 0, r_cnt = 0;
    logic [31:0] last_r_data;
    logic [1:0]  last_r_resp, last_b_resp;
    bit bp_rand = 0;

    initial begin
        int idx;
        logic [7:0]  a;
        logic [35:0] wv;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int k = 0; k < NR; k++) m_regs[k] = '0;
                q_aw.delete(); q_w.delete(); q_b.delete(); q_r.delete();
                m_up = 0;
                m_live = 1;
            end else if (m_live) begin
                if (bus.B_valid && bus.B_ready) begin
                    chk("b_expected", q_b.size() > 0, 1);
                    last_b_resp = bus.B_response;
                    if (q_b.size() > 0) void'(q_b.pop_front());
                    b_cnt++;
                end
                if (bus.R_valid && bus.R_ready) begin
                    chk("r_expected", q_r.size() > 0, 1);
                    last_r_data = bus.R_data;
                    last_r_resp = bus.R_response;
                    if (q_r.size() > 0) void'(q_r.pop_front());
                    r_cnt++;
                end
                if (bus.AR_valid && bus.AR_ready) begin
                    idx = int'(bus.AR_address[7:2]);
                    if (idx < NR) q_r.push_back({2'b00, m_regs[idx]});
                    else          q_r.push_back({2'b10, 32'h0});
                end
                if (bus.AW_valid && bus.AW_ready) q_aw.push_back(bus.AW_address);
                if (bus.W_valid && bus.W_ready)   q_w.push_back({bus.W_strb, bus.W_data});
                if (q_aw.size() > 0 && q_w.size() > 0) begin
                    a  = q_aw.pop_front();
                    wv = q_w.pop_front();
                    idx = int'(a[7:2]);
                    if (idx < LIM) begin
                        for (int b = 0; b < 4; b++)
                            if (wv[32+b]) m_regs[idx][8*b +: 8] = wv[8*b +: 8];
                        q_b.push_back(2'b00);
                    end else begin
                        q_b.push_back(2'b10);
                    end
                end
`ifdef AXIL_CYCLE_COUNTER_EN
                m_regs[NR-1] = m_regs[NR-1] + 32'd1;
`endif
                m_up = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        logic [NR*32-1:0] flat;
        forever begin
            @(negedge clk);
            if (m_live) begin
                for (int k = 0; k < NR; k++) flat[32*k +: 32] = m_regs[k];
                chk("regs_q", regs_q, flat);
                chk("aw_ready", bus.AW_ready, m_up && q_aw.size() == 0 && q_b.size() == 0);
                chk("w_ready",  bus.W_ready,  m_up && q_w.size() == 0 && q_b.size() == 0);
                chk("ar_ready", bus.AR_ready, m_up && q_r.size() == 0);
                chk("b_valid",  bus.B_valid,  q_b.size() != 0);
                chk("r_valid",  bus.R_valid,  q_r.size() != 0);
                if (q_b.size() != 0) chk("b_resp", bus.B_response, q_b[0]);
                if (q_r.size() != 0) chk("r_payload", {bus.R_response, bus.R_data}, q_r[0]);
                if (reset) chk("reset_payload", {bus.B_response, bus.R_response, bus.R_data}, 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bp_rand) begin
                bus.B_ready = 1'($urandom_range(0, 1));
                bus.R_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send_aw(input logic [7:0] a, input int d);
        int n = 0;
        repeat (d) @(negedge clk);
        bus.AW_address = a; bus.AW_valid = 1'b1;
        while (!bus.AW_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("aw_timeout", 0, 1);
        @(negedge clk); bus.AW_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] dt, input logic [3:0] s, input int d);
        int n = 0;
        repeat (d) @(negedge clk);
        bus.W_data = dt; bus.W_strb = s; bus.W_valid = 1'b1;
        while (!bus.W_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("w_timeout", 0, 1);
        @(negedge clk); bus.W_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] a, input int d);
        int n = 0;
        repeat (d) @(negedge clk);
        bus.AR_address = a; bus.AR_valid = 1'b1;
        while (!bus.AR_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("ar_timeout", 0, 1);
        @(negedge clk); bus.AR_valid = 1'b0;
    endtask

    task automatic wait_b(input int s);
        int n = 0;
        while (b_cnt == s && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("b_timeout", 0, 1);
    endtask

    task automatic wait_r(input int s);
        int n = 0;
        while (r_cnt == s && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("r_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] dt, input logic [3:0] s,
                            input int da, input int dw);
        int s0 = b_cnt;
        fork
            send_aw(a, da);
            send_w(dt, s, dw);
        join
        wait_b(s0);
    endtask

    task automatic do_read(input logic [7:0] a, input int d);
        int s0 = r_cnt;
        send_ar(a, d);
        wait_r(s0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        bus.AW_valid = 0; bus.AW_address = '0; bus.W_valid = 0; bus.W_data = '0;
        bus.W_strb = '0; bus.AR_valid = 0; bus.AR_address = '0;
        bus.B_ready = 1; bus.R_ready = 1;

        repeat (3) @(negedge clk);
        chk("rst_aw_ready", bus.AW_ready, 0);
        chk("rst_regs", regs_q, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {bus.AW_ready, bus.W_ready, bus.AR_ready}, 3'b111);

        // Same-cycle AW+W: response one cycle after the handshake
        s0 = b_cnt;
        fork
            send_aw(8'h04, 0);
            send_w(32'hDEADBEEF, 4'hF, 0);
        join
        chk("b_latency", bus.B_valid, 1);
        chk("b_okay", bus.B_response, 2'b00);
        chk("reg1_value", regs_q[63:32], 32'hDEADBEEF);
        wait_b(s0);
        do_read(8'h04, 0);
        chk("rd_reg1", {last_r_resp, last_r_data}, {2'b00, 32'hDEADBEEF});

        // Strobed partial writes, both arrival orders
        do_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(8'h08, 32'h11223344, 4'b0101, 0, 3);
        chk("strb_aw_first", regs_q[95:64], 32'hAA22CC44);
        do_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(8'h0A, 32'h11223344, 4'b0101, 3, 0);
        chk("strb_w_first", regs_q[95:64], 32'hAA22CC44);
        do_write(8'h0C, 32'h55667788, 4'h0, 1, 2);
        chk("strb_zero_okay", last_b_resp, 2'b00);

        // Out-of-range index
        do_write(8'h20, 32'h12345678, 4'hF, 0, 0);
        chk("oor_wr_resp", last_b_resp, 2'b10);
        chk("oor_regs", regs_q[95:32], {32'hAA22CC44, 32'hDEADBEEF});
        do_read(8'h20, 0);
        chk("oor_rd", {last_r_resp, last_r_data}, {2'b10, 32'h0});

        // Backpressure on both response channels
        bus.B_ready = 0; bus.R_ready = 0;
        s0 = b_cnt; s1 = r_cnt;
        fork
            send_aw(8'h0C, 0);
            send_w(32'hCAFEF00D, 4'hF, 0);
            send_ar(8'h04, 0);
        join
        repeat (5) begin
            chk("bp_valids", {bus.B_valid, bus.R_valid}, 2'b11);
            chk("bp_readies", {bus.AW_ready, bus.W_ready, bus.AR_ready}, 3'b000);
            chk("bp_payload", {bus.B_response, bus.R_response, bus.R_data}, {4'b0000, 32'hDEADBEEF});
            @(negedge clk);
        end
        bus.B_ready = 1; bus.R_ready = 1;
        @(negedge clk);
        chk("bp_release", {bus.B_valid, bus.R_valid, bus.AW_ready, bus.AR_ready}, 4'b0011);
        chk("bp_counts", (b_cnt - s0) * 4 + (r_cnt - s1), 5);

        // Read and write commit to the same register on the same edge
        do_write(8'h08, 32'h1, 4'hF, 0, 0);
        s0 = b_cnt; s1 = r_cnt;
        fork
            send_aw(8'h08, 0);
            send_w(32'h2, 4'hF, 1);
            send_ar(8'h08, 1);
        join
        wait_b(s0);
        wait_r(s1);
        chk("collision_old", last_r_data, 32'h1);
        do_read(8'h08, 0);
        chk("collision_new", last_r_data, 32'h2);

        // Randomized traffic with random response backpressure
        bp_rand = 1;
        for (int i = 0; i < 150; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                do_write(8'($urandom_range(0, 39)), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else if (op == 1) begin
                do_read(8'($urandom_range(0, 39)), int'($urandom_range(0, 3)));
            end else begin
                fork
                    do_write(8'($urandom_range(0, 39)), $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    do_read(8'($urandom_range(0, 39)), int'($urandom_range(0, 3)));
                join
            end
        end
        bp_rand = 0;
        @(negedge clk);
        bus.B_ready = 1; bus.R_ready = 1;
        repeat (3) @(negedge clk);

        // Reset while holding an address with no data yet
        do_write(8'h10, 32'h0F0F0F0F, 4'hF, 0, 0);
        send_aw(8'h10, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_regs", regs_q[NR*32-33:0], 0);
`ifdef AXIL_CYCLE_COUNTER_EN
        chk("midrst_cnt", regs_q[NR*32-1 -: 32], 1);
`else
        chk("midrst_top", regs_q[NR*32-1 -: 32], 0);
`endif
        chk("midrst_bvalid", bus.B_valid, 0);
        do_write(8'h10, 32'h00000005, 4'hF, 0, 0);
        chk("post_rst_write", regs_q[159:128], 32'h5);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
